// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the EX stage.
// Results are computed at the start edge and committed to HI/LO when the busy window ends.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  md_op,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_tmp_q, hi_tmp_d;
    logic [31:0]        lo_tmp_q, lo_tmp_d;
    logic               div_zero_q, div_zero_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_md;
    logic               is_div;
    logic               accept;

    logic signed [63:0] a_sext;
    logic signed [63:0] b_sext;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;

    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        b_mag_safe;
    logic [31:0]        uq_s;
    logic [31:0]        ur_s;
    logic [31:0]        div_q;
    logic [31:0]        div_r;
    logic [31:0]        b_safe;
    logic [31:0]        divu_q;
    logic [31:0]        divu_r;

    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    assign is_md  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign accept = (state_q == StIdle) && start && is_md;

    // Datapath: products and quotients, evaluated every cycle from the live operands.
    always_comb begin
        a_sext = {{32{a[31]}}, a};
        b_sext = {{32{b[31]}}, b};
        prod_s = a_sext * b_sext;
        prod_u = {32'd0, a} * {32'd0, b};

        // Signed divide via magnitudes; a zero divisor is steered to 1 so the
        // divider never sees 0 (its result is discarded anyway).
        a_mag      = a[31] ? (~a + 32'd1) : a;
        b_mag      = b[31] ? (~b + 32'd1) : b;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq_s       = a_mag / b_mag_safe;
        ur_s       = a_mag % b_mag_safe;
        div_q      = (a[31] ^ b[31]) ? (~uq_s + 32'd1) : uq_s;
        div_r      = a[31] ? (~ur_s + 32'd1) : ur_s;

        b_safe     = (b == 32'd0) ? 32'd1 : b;
        divu_q     = a / b_safe;
        divu_r     = a % b_safe;
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (md_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi = div_r;
                res_lo = div_q;
            end
            OP_DIVU: begin
                res_hi = divu_r;
                res_lo = divu_q;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // Next-state logic; anything presented while running is ignored.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_tmp_d   = hi_tmp_q;
        lo_tmp_d   = lo_tmp_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StRun;
                    cnt_d      = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    hi_tmp_d   = res_hi;
                    lo_tmp_d   = res_lo;
                    div_zero_d = is_div && (b == 32'd0);
                end else if (md_op == OP_MTHI) begin
                    hi_d = a;
                end else if (md_op == OP_MTLO) begin
                    lo_d = a;
                end
            end
            StRun: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (!div_zero_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_tmp_q   <= 32'd0;
            lo_tmp_q   <= 32'd0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_tmp_q   <= hi_tmp_d;
            lo_tmp_q   <= lo_tmp_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = (state_q == StRun);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the P6 pipelined MIPS core.
- Sits beside the single-cycle ALU. It consumes the same forwarded operands and a decoded op.
- Holds architectural HI/LO.
- Exposes start/busy to the hazard unit, which stalls any MD-class instruction in D while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (>=1).

Ports:
- clk  input  1  core clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- md_op  input  3  operation:
  - 000 none
  - 001 mult
  - 010 multu
  - 011 div
  - 100 divu
  - 101 mthi
  - 110 mtlo
  - 111 reserved (treated as none)
- start  input  1  EX instruction is a valid mult/multu/div/divu this cycle.
- a  input  32  rs operand (forwarded).
- b  input  32  rt operand (forwarded).
- busy  output  1  multi-cycle operation in progress.
- hi  output  32  HI register (mfhi source).
- lo  output  32  LO register (mflo source).

Behaviour:
- Reset (reset_n=0, async): hi=0, lo=0, busy=0, counter=0, pending result discarded. This applies immediately, including mid-operation.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter cnt).
- IDLE + start=1 + md_op in {001..100} at an edge:
  - Compute the result from a/b and latch it into internal hi_tmp/lo_tmp.
  - Load cnt = MULT_CYCLES or DIV_CYCLES according to md_op.
  - Enter RUN.
  - a/b need not be held after the start edge.
- RUN: cnt decrements each edge. On the edge where cnt==1:
  - hi<=hi_tmp, lo<=lo_tmp, busy<=0, return to IDLE.
  - busy is therefore high for exactly N cycles after the start cycle.
  - New HI/LO are visible the first cycle busy=0.
- Arithmetic:
  - mult: {hi,lo} = signed(a) * signed(b), 64-bit.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - div with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (b==0, div or divu): the unit still goes busy for DIV_CYCLES; hi/lo are left unchanged at completion.
- mthi/mtlo (md_op 101/110, start ignored), only when busy=0: hi<=a or lo<=a at the next edge. There is no busy period.
- Any md_op or start while busy=1 is ignored. The hazard unit guarantees this does not happen; the unit must still be robust to it.
- start with md_op in {000,101,110,111}: no multi-cycle operation; mthi/mtlo apply as above.
- hi/lo outputs are registers only. There is no combinational bypass of an in-flight result.
- Hazard contract: the stall condition is md-class-in-D && (start || busy).

Test Plan:
1. Reset mid-run:
   - Stimulus: start mult a=7 b=6, then assert reset_n=0 during the 2nd busy cycle.
   - Required: busy=0, hi=0, lo=0 immediately. After release, hi/lo stay 0.
2. Signed mult:
   - Stimulus: a=0xFFFFFFFE (-2), b=3.
   - Required: busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
   - Same operands via multu: hi=0x00000002, lo=0xFFFFFFFA.
3. Signed div:
   - Stimulus: a=-7 (0xFFFFFFF9), b=2.
   - Required: busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
   - Same operands via divu: lo=0x7FFFFFFC, hi=0x00000001.
4. Divide by zero:
   - Stimulus: preload hi=0x11 via mthi and lo=0x22 via mtlo, then div a=5 b=0.
   - Required: busy 10 cycles, then hi=0x11, lo=0x22.
5. Ignored ops while busy:
   - Stimulus: during a mult busy window, present mtlo a=0xDEAD and start div.
   - Required: both ignored; the final lo/hi equal the mult product; busy falls after exactly 5 cycles.
6. Back-to-back:
   - Stimulus: start multu a=0xFFFFFFFF b=0xFFFFFFFF on the first cycle busy=0 after a previous div.
   - Required: accepted; hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
